// File: rtl/counter_run_ctrl.sv
// Run-counter sequencer: start/stop/hold control, up/down counting toward a captured
// terminal value, optional auto-reload and a prescaled count rate.
module counter_run_ctrl #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             up,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             up_q, up_d;
  logic             reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic             tick;

  assign start_val = up_q ? '0 : limit_q;
  assign term_val  = up_q ? limit_q : '0;
  assign tick      = (presc_q == PMAX);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    presc_d  = presc_q;
    up_d     = up_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (start) begin
          up_d     = up;
          reload_d = auto_reload;
          limit_d  = limit;
          count_d  = up ? '0 : limit;
          presc_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (hold) begin
          // hold is a level freeze: count and prescaler keep their values
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (tick) begin
            presc_d = '0;
            if (count_q != term_val) begin
              count_d = up_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else if (reload_q) begin
              count_d = start_val;
              done_d  = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        presc_d = '0;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      presc_q  <= '0;
      up_q     <= 1'b0;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      presc_q  <= presc_d;
      up_q     <= up_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl: one PRESCALE=1 instance and one PRESCALE=4
// instance sharing the same control inputs.
module tb_counter_run_ctrl;

  logic       clk;
  logic       reset;
  logic       start, stop, hold, up, auto_reload;
  logic [2:0] limit;

  logic [2:0] count1, count4;
  logic       busy1, busy4, done1, done4;
  logic [1:0] state1, state4;

  int n_assert = 0;
  int n_fail   = 0;

  counter_run_ctrl #(.WIDTH(3), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .up(up), .auto_reload(auto_reload), .limit(limit),
    .count(count1), .busy(busy1), .done(done1), .state(state1)
  );

  counter_run_ctrl #(.WIDTH(3), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .up(up), .auto_reload(auto_reload), .limit(limit),
    .count(count4), .busy(busy4), .done(done4), .state(state4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [2:0] c, input logic b,
                      input logic d, input logic [1:0] s);
    chk({tag, ".count"}, 32'(count1), 32'(c));
    chk({tag, ".busy"},  32'(busy1),  32'(b));
    chk({tag, ".done"},  32'(done1),  32'(d));
    chk({tag, ".state"}, 32'(state1), 32'(s));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    up = 1'b0; auto_reload = 1'b0; limit = 3'd0;
    #2;
    chk1("reset", 3'd0, 1'b0, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    tick();

    // up, limit=5, one-shot
    up = 1'b1; limit = 3'd5; auto_reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("up5_e0", 3'd0, 1'b1, 1'b0, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk1($sformatf("up5_e%0d", k), 3'(k), 1'b1, 1'b0, 2'b01);
    end
    tick();
    chk1("up5_done", 3'd5, 1'b0, 1'b1, 2'b11);
    tick();
    chk1("up5_after", 3'd5, 1'b0, 1'b0, 2'b11);

    // restart from DONE: down, limit=7, auto-reload; start and limit change mid-run ignored
    up = 1'b0; limit = 3'd7; auto_reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("dn7_e0", 3'd7, 1'b1, 1'b0, 2'b01);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 8; k++) begin
        if (p == 1 && k == 3) begin
          start = 1'b1; limit = 3'd3; up = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
        chk1($sformatf("dn7_p%0d_k%0d", p, k), (k == 8) ? 3'd7 : 3'(7 - k),
             1'b1, (k == 8), 2'b01);
      end
    end
    tick();
    chk1("dn7_last", 3'd6, 1'b1, 1'b0, 2'b01);

    // asynchronous reset in the middle of a run
    reset = 1'b1;
    #1;
    chk1("async_rst", 3'd0, 1'b0, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    tick();

    // hold at count 3, release, then stop from HOLD
    up = 1'b1; limit = 3'd6; auto_reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk1("hold_pre", 3'd3, 1'b1, 1'b0, 2'b01);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("hold_%0d", k), 3'd3, 1'b1, 1'b0, 2'b10);
    end
    hold = 1'b0;
    tick();
    chk1("hold_rel", 3'd4, 1'b1, 1'b0, 2'b01);
    hold = 1'b1;
    tick();
    chk1("hold_again", 3'd4, 1'b1, 1'b0, 2'b10);
    stop = 1'b1;
    tick();
    stop = 1'b0; hold = 1'b0;
    chk1("hold_stop", 3'd0, 1'b0, 1'b0, 2'b00);

    // start and stop on the same edge in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk1("start_stop", 3'd0, 1'b0, 1'b0, 2'b00);

    // limit=0 boundary, then stop from DONE
    up = 1'b1; limit = 3'd0; auto_reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("lim0_e0", 3'd0, 1'b1, 1'b0, 2'b01);
    tick();
    chk1("lim0_done", 3'd0, 1'b0, 1'b1, 2'b11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk1("lim0_stop", 3'd0, 1'b0, 1'b0, 2'b00);

    // PRESCALE=4 instance: up, limit=2 -> done 12 cycles after start
    chk("p4_idle.state", 32'(state4), 32'(2'b00));
    up = 1'b1; limit = 3'd2; auto_reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p4_e0.count", 32'(count4), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("p4_c%0d.count", c), 32'(count4), (c == 12) ? 32'd2 : 32'(c / 4));
      chk($sformatf("p4_c%0d.done", c), 32'(done4), 32'(c == 12));
      chk($sformatf("p4_c%0d.state", c), 32'(state4), (c == 12) ? 32'd3 : 32'd1);
    end
    tick();
    chk("p4_after.done", 32'(done4), 32'd0);
    chk("p4_after.busy", 32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
